jtag_mem_bridge: RTL and testbench



---
 rtl/jtag_mem_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/jtag_mem_bridge.sv | 155 +++++++++++++++
 tb/tb_jtag_mem_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_mem_pkg.sv
// Shared types and constants for the JTAG-to-memory bridge.
package jtag_mem_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

    localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD,
        WAIT_REL
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic jtag_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jtag_mem_bridge.sv
// Bridges tck-domain sel/ready level handshake to an acknowledged memory port in clk.
// Optional access timeout with sticky err output: define JTAG_MEM_TIMEOUT_EN.
module jtag_mem_bridge
    import jtag_mem_pkg::*;
#(
    parameter int AW              = DEF_AW,
    parameter int DW              = DEF_DW,
    parameter int MIN_BUSY_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic          clk,
    input  logic          jtag_rst_n,
    input  logic          sel,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
`ifdef JTAG_MEM_TIMEOUT_EN
    ,
    output logic          err
`endif
);

    localparam int BCW = $clog2(MIN_BUSY_CYCLES + 1);
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(MIN_BUSY_CYCLES - 1);

    state_t         state, state_next;
    logic           sel_s, sel_d, sel_rise;
    logic [BCW-1:0] busy_cnt;
    logic           do_capture, do_complete, do_timeout, do_release;

    sync_2ff u_sel_sync (
        .clk        (clk),
        .jtag_rst_n (jtag_rst_n),
        .d          (sel),
        .q          (sel_s)
    );

    assign sel_rise = sel_s & ~sel_d;

`ifdef JTAG_MEM_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] to_cnt;

    always_ff @(posedge clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (do_capture) begin
                to_cnt <= '0;
                err    <= 1'b0;
            end else if (state == ACCESS && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (do_timeout)
                err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_capture  = 1'b0;
        do_complete = 1'b0;
        do_timeout  = 1'b0;
        do_release  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_rise) begin
                    do_capture = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    do_complete = 1'b1;
                    state_next  = HOLD;
                end
`ifdef JTAG_MEM_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    do_timeout = 1'b1;
                    state_next = HOLD;
                end
`endif
            end
            HOLD: begin
                if (busy_cnt >= BUSY_LAST) begin
                    do_release = 1'b1;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                // Re-arm only once sel is seen low, so a held sel cannot retrigger.
                if (!sel_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            sel_d     <= 1'b0;
            ready     <= 1'b1;
            rdata     <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy_cnt  <= '0;
        end else begin
            sel_d <= sel_s;
            if ((state == ACCESS || state == HOLD) && busy_cnt != '1)
                busy_cnt <= busy_cnt + 1'b1;
            if (do_capture) begin
                mem_addr  <= addr;
                mem_we    <= we;
                mem_wdata <= wdata;
                mem_cs    <= 1'b1;
                ready     <= 1'b0;
                busy_cnt  <= '0;
            end
            if (do_complete) begin
                mem_cs <= 1'b0;
                if (!mem_we)
                    rdata <= mem_rdata;
            end
            if (do_timeout) begin
                mem_cs <= 1'b0;
                if (!mem_we)
                    rdata <= DW'(TIMEOUT_RDATA);
            end
            if (do_release)
                ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Directed self-checking bench for jtag_mem_bridge (timeout steps under JTAG_MEM_TIMEOUT_EN).
module tb_jtag_mem_bridge;
    import jtag_mem_pkg::*;

`ifdef JTAG_MEM_TIMEOUT_EN
    localparam int unsigned RD_ACK = 12;
`else
    localparam int unsigned RD_ACK = 20;
`endif

    logic        clk = 1'b0;
    logic        jtag_rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        ready;
    logic [15:0] rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef JTAG_MEM_TIMEOUT_EN
    logic        err;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        hold_cs;

    jtag_mem_bridge #(
        .AW              (8),
        .DW              (16),
        .MIN_BUSY_CYCLES (8),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .jtag_rst_n (jtag_rst_n),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef JTAG_MEM_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int unsigned max_cycles);
        int unsigned n = 0;
        while (ready !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef JTAG_MEM_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        jtag_rst_n = 1'b1;
        tick();
        tick();

        // Write, ack sampled two edges after cs rises
        we = 1'b1; addr = 8'h3C; wdata = 16'hA5A5; sel = 1'b1;
        tick();
        tick();
        check("wr_cs_not_yet", 32'(mem_cs), 32'd0);
        tick();
        check("wr_cs", 32'(mem_cs), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'h3C);
        check("wr_wdata", 32'(mem_wdata), 32'hA5A5);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_ready_low", 32'(ready), 32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_cs_drop", 32'(mem_cs), 32'd0);
        repeat (5) tick();
        check("wr_ready_e7", 32'(ready), 32'd0);
        tick();
        check("wr_ready_e8", 32'(ready), 32'd1);
        check("wr_rdata_kept", 32'(rdata), 32'd0);

        // sel still held after ready returns: no re-execution
        hold_cs = 1'b0;
        repeat (6) begin
            tick();
            if (mem_cs) hold_cs = 1'b1;
        end
        check("rel_no_reaccess", 32'(hold_cs), 32'd0);
        check("rel_wait_state", 32'(dut.state), 32'(WAIT_REL));
        sel = 1'b0;
        repeat (4) tick();
        check("rel_idle", 32'(dut.state), 32'(IDLE));

        // Late-acked read
        we = 1'b0; addr = 8'h10; wdata = '0; mem_rdata = 16'h1234; sel = 1'b1;
        repeat (3) tick();
        check("rd_cs", 32'(mem_cs), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'h10);
        check("rd_we", 32'(mem_we), 32'd0);
        repeat (RD_ACK - 1) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rd_cs_drop", 32'(mem_cs), 32'd0);
        check("rd_ready_ack_edge", 32'(ready), 32'd0);
        check("rd_rdata", 32'(rdata), 32'h1234);
        tick();
        check("rd_ready_next", 32'(ready), 32'd1);
        mem_rdata = 16'hFFFF;
        sel = 1'b0;
        repeat (4) tick();
        check("rd_rdata_sel_low", 32'(rdata), 32'h1234);

        we = 1'b1; addr = 8'h55; wdata = 16'h0F0F; sel = 1'b1;
        repeat (3) tick();
        check("wr2_cs", 32'(mem_cs), 32'd1);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wait_ready("wr2_ready", 20);
        check("wr2_rdata_kept", 32'(rdata), 32'h1234);
        sel = 1'b0;
        repeat (4) tick();

        // Reset in the middle of an access
        we = 1'b0; addr = 8'h22; mem_rdata = 16'h0000; sel = 1'b1;
        repeat (3) tick();
        check("rst_mid_cs_pre", 32'(mem_cs), 32'd1);
        jtag_rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_cs", 32'(mem_cs), 32'd0);
        check("rst_mid_rdata", 32'(rdata), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        jtag_rst_n = 1'b1;
        repeat (4) tick();
        addr = 8'h44; mem_rdata = 16'hBEEF; sel = 1'b1;
        repeat (3) tick();
        check("post_rst_cs", 32'(mem_cs), 32'd1);
        check("post_rst_addr", 32'(mem_addr), 32'h44);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wait_ready("post_rst_ready", 20);
        check("post_rst_rdata", 32'(rdata), 32'hBEEF);
        sel = 1'b0;
        repeat (4) tick();

        // Spurious ack in IDLE, then sel dropped mid-access
        mem_rdata = 16'h7777;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check("spur_cs", 32'(mem_cs), 32'd0);
        check("spur_ready", 32'(ready), 32'd1);
        check("spur_rdata", 32'(rdata), 32'hBEEF);
        check("spur_state", 32'(dut.state), 32'(IDLE));
        addr = 8'h66; mem_rdata = 16'h5A5A; sel = 1'b1;
        repeat (3) tick();
        check("mid_cs", 32'(mem_cs), 32'd1);
        sel = 1'b0;
        repeat (3) tick();
        check("mid_cs_held", 32'(mem_cs), 32'd1);
        check("mid_ready_low", 32'(ready), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("mid_cs_drop", 32'(mem_cs), 32'd0);
        check("mid_rdata", 32'(rdata), 32'h5A5A);
        wait_ready("mid_ready", 20);
        check("mid_wait_rel", 32'(dut.state), 32'(WAIT_REL));
        tick();
        check("mid_idle", 32'(dut.state), 32'(IDLE));
        repeat (2) tick();

`ifdef JTAG_MEM_TIMEOUT_EN
        // Read that never gets an ack
        we = 1'b0; addr = 8'h77; mem_rdata = 16'h1111; sel = 1'b1;
        repeat (3) tick();
        check("to_cs", 32'(mem_cs), 32'd1);
        check("to_err_clear", 32'(err), 32'd0);
        repeat (15) tick();
        check("to_cs_e15", 32'(mem_cs), 32'd1);
        tick();
        check("to_cs_e16", 32'(mem_cs), 32'd0);
        check("to_rdata", 32'(rdata), 32'hDEAD);
        check("to_err", 32'(err), 32'd1);
        tick();
        check("to_ready", 32'(ready), 32'd1);
        sel = 1'b0;
        repeat (4) tick();
        check("to_err_sticky", 32'(err), 32'd1);
        we = 1'b1; addr = 8'h01; wdata = 16'h0001; sel = 1'b1;
        repeat (2) tick();
        check("to_err_before_rise", 32'(err), 32'd1);
        tick();
        check("to_err_cleared", 32'(err), 32'd0);
        check("to_next_cs", 32'(mem_cs), 32'd1);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wait_ready("to_next_ready", 20);
        sel = 1'b0;
        repeat (4) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
